// File: rtl/mem_wb_pipe_pkg.sv
// Shared types and constants for the MEM/WB pipeline slice.
package mem_wb_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  // Register $0 is hard-wired to zero; writes to it never reach the register file.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Memory-access sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] reg_addr;
  } ex_mem_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic              reg_write;
    logic [DATA_W-1:0] reg_wdata;
    logic [ADDR_W-1:0] reg_addr;
  } mem_wb_t;

  // A register write is only real when it targets something other than $0.
  function automatic logic wr_enable(input logic we, input logic [ADDR_W-1:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/mem_wb.sv
// The MEM/WB stage is implemented in mem_wb_pipe.sv.

// File: rtl/mem_wb_pipe_reg.sv
// Generic pipeline register with load enable and synchronous clear.
// Clear wins over enable so a bubble or reset always lands.
module pipe_reg #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Register update: clear first, then optional load.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM stage of the pipeline: EX/MEM and MEM/WB registers, the data-memory
// request/ready sequencer with stall generation, a sticky timeout flag, and
// the writeback mux. Also exports the EX/MEM and MEM/WB forwarding sources.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite_ex,
  input  logic                MemToReg_ex,
  input  logic                MemWrite_ex,
  input  logic [DATA_W-1:0]   ALUResult_ex,
  input  logic [DATA_W-1:0]   MemWriteData_ex,
  input  logic [ADDR_W-1:0]   RegWriteAddr_ex,
  output logic                DmemReq,
  output logic                DmemWe,
  output logic [DATA_W-1:0]   DmemAddr,
  output logic [DATA_W-1:0]   DmemWdata,
  input  logic [DATA_W-1:0]   DmemRdata,
  input  logic                DmemReady,
  output logic                MemStall,
  output logic                DmemErr,
  output logic [DATA_W-1:0]   ALUResult_mem,
  output logic [ADDR_W-1:0]   RegWriteAddr_mem,
  output logic                RegWrite_mem,
  output logic [DATA_W-1:0]   RegWriteData_wb,
  output logic [ADDR_W-1:0]   RegWriteAddr_wb,
  output logic                RegWrite_wb
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

  ex_mem_t           ex_in;
  ex_mem_t           ex_mem_q;
  mem_wb_t           wb_in;
  mem_wb_t           mem_wb_q;
  mem_state_t        state_q;
  mem_state_t        state_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              err_q;
  logic              memop;
  logic              req;
  logic              stall;

  // Pack the EX-stage controls and data into the EX/MEM record.
  always_comb begin
    ex_in            = '0;
    ex_in.reg_write  = RegWrite_ex;
    ex_in.mem_to_reg = MemToReg_ex;
    ex_in.mem_write  = MemWrite_ex;
    ex_in.alu_result = ALUResult_ex;
    ex_in.mem_wdata  = MemWriteData_ex;
    ex_in.reg_addr   = RegWriteAddr_ex;
  end

  // ---- EX -> MEM boundary: frozen while a memory access is outstanding ----
  pipe_reg #(.N($bits(ex_mem_t))) u_ex_mem (
    .clk (clk),
    .en  (!stall),
    .clr (reset),
    .d   (ex_in),
    .q   (ex_mem_q)
  );

  assign memop = ex_mem_q.mem_to_reg | ex_mem_q.mem_write;

  // Sequencer next state and request/stall outputs. The held EX/MEM entry
  // keeps address, data and direction stable until the access completes.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (memop) begin
            req = 1'b1;
            if (!DmemReady) begin
              stall   = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          req = 1'b1;
          if (DmemReady) begin
            state_d = ST_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter: number of stall cycles spent on the current access,
  // saturating at MAX_WAIT; returns to zero whenever the stage is not stalled.
  always_comb begin
    wait_cnt_d = '0;
    if (stall) begin
      wait_cnt_d = (wait_cnt_q == MAX_W) ? MAX_W : wait_cnt_q + CNT_W'(1);
    end
  end

  // Counter and sticky timeout flag. The flag sets on the edge that closes
  // the MAX_WAIT-th stall cycle and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (wait_cnt_d == MAX_W) begin
        err_q <= 1'b1;
      end
    end
  end

  // Writeback select: loads take memory read data, everything else the ALU result.
  always_comb begin
    wb_in           = '0;
    wb_in.reg_write = ex_mem_q.reg_write;
    wb_in.reg_wdata = ex_mem_q.mem_to_reg ? DmemRdata : ex_mem_q.alu_result;
    wb_in.reg_addr  = ex_mem_q.reg_addr;
  end

  // ---- MEM -> WB boundary: loads every edge, bubble while stalled ----
  pipe_reg #(.N($bits(mem_wb_t))) u_mem_wb (
    .clk (clk),
    .en  (1'b1),
    .clr (reset | stall),
    .d   (wb_in),
    .q   (mem_wb_q)
  );

  assign DmemReq          = req;
  assign DmemWe           = ex_mem_q.mem_write;
  assign DmemAddr         = ex_mem_q.alu_result;
  assign DmemWdata        = ex_mem_q.mem_wdata;
  assign MemStall         = stall;
  assign DmemErr          = err_q;
  assign ALUResult_mem    = ex_mem_q.alu_result;
  assign RegWriteAddr_mem = ex_mem_q.reg_addr;
  assign RegWrite_mem     = wr_enable(ex_mem_q.reg_write, ex_mem_q.reg_addr);
  assign RegWriteData_wb  = mem_wb_q.reg_wdata;
  assign RegWriteAddr_wb  = mem_wb_q.reg_addr;
  assign RegWrite_wb      = wr_enable(mem_wb_q.reg_write, mem_wb_q.reg_addr);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_mem_wb_pipe;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_ex, MemToReg_ex, MemWrite_ex;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  RegWriteAddr_ex;
  logic        DmemReq, DmemWe;
  logic [31:0] DmemAddr, DmemWdata, DmemRdata;
  logic        DmemReady, MemStall, DmemErr;
  logic [31:0] ALUResult_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic        RegWrite_wb;

  int n_total = 0;
  int n_bad   = 0;

  mem_wb_pipe #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_ex(RegWrite_ex), .MemToReg_ex(MemToReg_ex), .MemWrite_ex(MemWrite_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .RegWriteAddr_ex(RegWriteAddr_ex),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWdata(DmemWdata),
    .DmemRdata(DmemRdata), .DmemReady(DmemReady),
    .MemStall(MemStall), .DmemErr(DmemErr),
    .ALUResult_mem(ALUResult_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_mem(RegWrite_mem),
    .RegWriteData_wb(RegWriteData_wb), .RegWriteAddr_wb(RegWriteAddr_wb),
    .RegWrite_wb(RegWrite_wb)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the instruction sitting in MEM, the result sitting in WB,
  // how long the current access has waited, and the sticky timeout flag.
  typedef struct packed {
    bit        rw;
    bit        m2r;
    bit        mw;
    bit [31:0] alu;
    bit [31:0] wd;
    bit [4:0]  a;
  } slot_t;

  slot_t     m_mem;
  bit        m_wb_rw;
  bit [31:0] m_wb_d;
  bit [4:0]  m_wb_a;
  int        m_waits;
  bit        m_err;
  bit        last_stall;

  // Compare all outputs with the model, then advance the model by one edge.
  task automatic model_step();
    bit memop, e_req, e_stall;
    memop   = m_mem.m2r | m_mem.mw;
    e_req   = !reset && memop;
    e_stall = e_req && !DmemReady;
    expect_eq("req",      32'(DmemReq),          32'(e_req));
    expect_eq("stall",    32'(MemStall),         32'(e_stall));
    expect_eq("we",       32'(DmemWe),           32'(m_mem.mw));
    expect_eq("daddr",    DmemAddr,              m_mem.alu);
    expect_eq("wdata",    DmemWdata,             m_mem.wd);
    expect_eq("alu_mem",  ALUResult_mem,         m_mem.alu);
    expect_eq("addr_mem", 32'(RegWriteAddr_mem), 32'(m_mem.a));
    expect_eq("rw_mem",   32'(RegWrite_mem),     32'(m_mem.rw && m_mem.a != 0));
    expect_eq("data_wb",  RegWriteData_wb,       m_wb_d);
    expect_eq("addr_wb",  32'(RegWriteAddr_wb),  32'(m_wb_a));
    expect_eq("rw_wb",    32'(RegWrite_wb),      32'(m_wb_rw && m_wb_a != 0));
    expect_eq("err",      32'(DmemErr),          32'(m_err));
    last_stall = e_stall;
    if (reset) begin
      m_mem = '0; m_wb_rw = 0; m_wb_d = 0; m_wb_a = 0; m_waits = 0; m_err = 0;
    end else if (e_stall) begin
      m_wb_rw = 0; m_wb_d = 0; m_wb_a = 0;
      m_waits = (m_waits + 1 > MAXW) ? MAXW : m_waits + 1;
      if (m_waits == MAXW) m_err = 1;
    end else begin
      m_wb_rw = m_mem.rw;
      m_wb_d  = m_mem.m2r ? DmemRdata : m_mem.alu;
      m_wb_a  = m_mem.a;
      m_waits = 0;
      m_mem   = '{rw: RegWrite_ex, m2r: MemToReg_ex, mw: MemWrite_ex,
                  alu: ALUResult_ex, wd: MemWriteData_ex, a: RegWriteAddr_ex};
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit rw, input bit m2r, input bit mw,
                        input bit [31:0] alu, input bit [31:0] wd, input bit [4:0] a);
    RegWrite_ex = rw; MemToReg_ex = m2r; MemWrite_ex = mw;
    ALUResult_ex = alu; MemWriteData_ex = wd; RegWriteAddr_ex = a;
  endtask

  task automatic set_nop();
    set_ex(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mem = '0; m_wb_rw = 0; m_wb_d = 0; m_wb_a = 0; m_waits = 0; m_err = 0;
    last_stall = 0;
    reset = 1; DmemReady = 0; DmemRdata = 0;
    set_nop();
    @(posedge clk); #1;
    cycle();
    #2;
    expect_eq("rst_req",   32'(DmemReq), 0);
    expect_eq("rst_stall", 32'(MemStall), 0);
    expect_eq("rst_alu",   ALUResult_mem, 0);
    expect_eq("rst_rwwb",  32'(RegWrite_wb), 0);
    expect_eq("rst_err",   32'(DmemErr), 0);
    reset = 0;
    cycle();

    // ALU chain: $8=5 then $8=7 back to back.
    set_ex(1, 0, 0, 32'd5, 0, 5'd8);
    cycle();
    set_ex(1, 0, 0, 32'd7, 0, 5'd8);
    cycle();
    set_nop();
    #2;
    expect_eq("chain_alu_mem", ALUResult_mem, 32'd7);
    expect_eq("chain_rw_mem",  32'(RegWrite_mem), 1);
    expect_eq("chain_data_wb", RegWriteData_wb, 32'd5);
    expect_eq("chain_addr_wb", 32'(RegWriteAddr_wb), 8);
    expect_eq("chain_stall",   32'(MemStall), 0);
    cycle();

    // Zero-wait load into $9.
    DmemReady = 1; DmemRdata = 32'hDEADBEEF;
    set_ex(1, 1, 0, 32'h100, 0, 5'd9);
    cycle();
    set_nop();
    #2;
    expect_eq("ld_req",   32'(DmemReq), 1);
    expect_eq("ld_stall", 32'(MemStall), 0);
    cycle();
    #2;
    expect_eq("ld_data_wb", RegWriteData_wb, 32'hDEADBEEF);
    expect_eq("ld_rw_wb",   32'(RegWrite_wb), 1);
    expect_eq("ld_addr_wb", 32'(RegWriteAddr_wb), 9);
    DmemReady = 0;

    // Store 0x1234 to 0x40, ready on the fourth request cycle.
    set_ex(0, 0, 1, 32'h40, 32'h1234, 0);
    cycle();
    set_nop();
    for (int i = 0; i < 4; i++) begin
      DmemReady = (i == 3);
      #2;
      expect_eq("st_req",   32'(DmemReq), 1);
      expect_eq("st_we",    32'(DmemWe), 1);
      expect_eq("st_addr",  DmemAddr, 32'h40);
      expect_eq("st_wdata", DmemWdata, 32'h1234);
      expect_eq("st_stall", 32'(MemStall), 32'(i < 3));
      if (i > 0) expect_eq("st_bubble", 32'(RegWrite_wb), 0);
      cycle();
    end
    DmemReady = 0;
    #2;
    expect_eq("st_done_req", 32'(DmemReq), 0);
    expect_eq("st_err",      32'(DmemErr), 0);
    cycle();

    // Write to $0 never becomes a register write.
    set_ex(1, 0, 0, 32'h55, 0, 5'd0);
    cycle();
    #2;
    expect_eq("z_rw_mem", 32'(RegWrite_mem), 0);
    set_nop();
    cycle();
    #2;
    expect_eq("z_rw_wb", 32'(RegWrite_wb), 0);

    // Timeout: ready withheld 10 cycles with MAX_WAIT=4.
    set_ex(1, 1, 0, 32'h80, 0, 5'd10);
    cycle();
    set_nop();
    for (int i = 0; i < 10; i++) begin
      DmemReady = 0;
      #2;
      expect_eq("to_stall", 32'(MemStall), 1);
      expect_eq("to_err",   32'(DmemErr), 32'(i >= 4));
      cycle();
    end
    DmemReady = 1; DmemRdata = 32'h0BADF00D;
    #2;
    expect_eq("to_done_stall", 32'(MemStall), 0);
    expect_eq("to_err_hold",   32'(DmemErr), 1);
    cycle();
    DmemReady = 0;
    #2;
    expect_eq("to_data_wb", RegWriteData_wb, 32'h0BADF00D);
    expect_eq("to_err_sticky", 32'(DmemErr), 1);
    cycle();

    // Reset while waiting abandons the access.
    set_ex(1, 1, 0, 32'h200, 0, 5'd11);
    cycle();
    set_nop();
    #2;
    expect_eq("rw_stall0", 32'(MemStall), 1);
    cycle();
    #2;
    expect_eq("rw_req_wait", 32'(DmemReq), 1);
    reset = 1;
    #1;
    expect_eq("rw_req_rst",   32'(DmemReq), 0);
    expect_eq("rw_stall_rst", 32'(MemStall), 0);
    cycle();
    reset = 0;
    #2;
    expect_eq("rw_req_after", 32'(DmemReq), 0);
    expect_eq("rw_err_after", 32'(DmemErr), 0);
    expect_eq("rw_rwmem",     32'(RegWrite_mem), 0);
    expect_eq("rw_rwwb",      32'(RegWrite_wb), 0);
    expect_eq("rw_alu",       ALUResult_mem, 0);
    DmemReady = 1; DmemRdata = 32'hCAFEF00D;
    cycle();
    DmemReady = 0;
    #2;
    expect_eq("rw_spurious_rw",   32'(RegWrite_wb), 0);
    expect_eq("rw_spurious_data", RegWriteData_wb, 0);
    cycle();

    // Randomized traffic; the front end holds its instruction while stalled.
    for (int n = 0; n < 800; n++) begin
      if (!last_stall) begin
        int k;
        k = $urandom_range(0, 3);
        set_ex(0, 0, 0, $urandom, $urandom, 5'($urandom_range(0, 7)));
        case (k)
          2:       begin RegWrite_ex = 1; MemToReg_ex = 1; end
          3:       begin MemWrite_ex = 1; RegWrite_ex = 1'($urandom_range(0, 1)); end
          default: RegWrite_ex = 1;
        endcase
      end
      DmemReady = ($urandom_range(0, 2) != 0);
      DmemRdata = $urandom;
      reset     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
